// File: rtl/rf_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rf_ctrl_pkg
// Shared types and constants for the register-file write-back scheduler.
//   REG_AW    : register index width (32 architectural registers)
//   NUM_REGS  : number of architectural registers
//   DATA_W    : register data width
//   reg_idx_t : register index type
//   data_t    : register data type
//   gnt_src_e : which source owns the write port in a given cycle
// ---------------------------------------------------------------------------
package rf_ctrl_pkg;

  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 32;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_LL   = 2'd2
  } gnt_src_e;

  // A request only competes for the write port when it targets a real
  // register; r0 writes are swallowed without using the port.
  function automatic logic needs_port(input logic valid, input reg_idx_t rd);
    return valid && (rd != '0);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Tracks registers awaiting a long-latency result and decides whether the
// issue stage must hold its instruction.
//   clk, rst            : clock, asynchronous active-high reset
//   iss_valid           : issue stage presents an instruction
//   iss_rs1/iss_rs2     : source registers checked for RAW hazards
//   iss_rd              : destination checked for WAW hazards, marked busy
//   iss_ll              : instruction completes through the long-latency unit
//   ll_ret              : a long-latency result is accepted this cycle
//   ll_ret_rd           : destination of the accepted long-latency result
//   iss_stall           : issue must hold the instruction this cycle
//   out_cnt             : number of long-latency ops in flight
// ---------------------------------------------------------------------------
module rf_scoreboard
  import rf_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rs1,
  input  logic [REG_AW-1:0] iss_rs2,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic              iss_ll,
  input  logic              ll_ret,
  input  logic [REG_AW-1:0] ll_ret_rd,
  output logic              iss_stall,
  output logic [CNT_W-1:0]  out_cnt
);

  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic                hazard;
  logic                at_limit;
  logic                issue_ll;

  // Hazards are judged on the registered busy bits only: a result accepted
  // this cycle unblocks dependants on the next cycle, never the same one.
  assign hazard    = iss_valid && (busy_q[iss_rs1] || busy_q[iss_rs2] || busy_q[iss_rd]);
  assign at_limit  = (out_cnt_q == MAX_OUT_C);
  assign iss_stall = hazard || (iss_ll && at_limit);
  assign issue_ll  = iss_valid && !iss_stall && iss_ll;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    busy_d    = busy_q;
    out_cnt_d = out_cnt_q;

    // Clear before set: if both ever hit the same register, the new
    // reservation survives.
    if (ll_ret) begin
      busy_d[ll_ret_rd] = 1'b0;
    end
    if (issue_ll && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    // Simultaneous issue and return cancel out. Both edges saturate so the
    // counter can never wrap on illegal input.
    unique case ({issue_ll, ll_ret})
      2'b10: if (!at_limit) out_cnt_d = out_cnt_q + 1'b1;
      2'b01: if (out_cnt_q != '0) out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // NOTE: the busy vector is plain flops, not a RAM, so it takes the async
  // reset like any other state; a reset must drop every pending reservation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      out_cnt_q <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      busy_q    <= busy_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign out_cnt = out_cnt_q;

endmodule

// File: rtl/rf_wb_sched.sv
// ---------------------------------------------------------------------------
// rf_wb_sched
// Write-back scheduler for the 32x32 register file. Shares the single write
// port between the in-order pipeline write-back and the long-latency unit,
// and stalls issue while a long-latency destination or source is pending.
//   clk, rst                  : clock, asynchronous active-high reset
//   iss_valid/rs1/rs2/rd/ll   : instruction presented by the issue stage
//   iss_stall                 : issue must hold the instruction
//   wb_valid/rd/data          : pipeline write-back request
//   wb_ready                  : pipeline write-back accepted this cycle
//   ll_valid/rd/data          : long-latency result request
//   ll_ready                  : long-latency result accepted this cycle
//   RFWr, A3, WD              : registered register-file write port
//   busy_cnt                  : long-latency ops in flight (debug)
// ---------------------------------------------------------------------------
module rf_wb_sched
  import rf_ctrl_pkg::*;
#(
  parameter int MAX_WAIT        = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rs1,
  input  logic [REG_AW-1:0] iss_rs2,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic              iss_ll,
  output logic              iss_stall,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              ll_valid,
  input  logic [REG_AW-1:0] ll_rd,
  input  logic [DATA_W-1:0] ll_data,
  output logic              ll_ready,
  output logic              RFWr,
  output logic [REG_AW-1:0] A3,
  output logic [DATA_W-1:0] WD,
  output logic [CNT_W-1:0]  busy_cnt
);

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             ll_prio;
  logic             wb_live;
  logic             ll_live;
  gnt_src_e         gnt;

  logic     rfwr_q, rfwr_d;
  reg_idx_t a3_q, a3_d;
  data_t    wd_q, wd_d;

  // -------------------------------------------------------------------------
  // Arbitration. The pipeline owns the port by default; once the long-latency
  // source has been refused MAX_WAIT cycles in a row it takes priority for a
  // cycle, which bounds its wait to MAX_WAIT+1 cycles. A request to r0 never
  // needs the port, so it is always accepted and never blocks the other side.
  // -------------------------------------------------------------------------
  assign ll_prio = (wait_cnt_q >= MAX_WAIT_C);
  assign wb_live = needs_port(wb_valid, wb_rd);
  assign ll_live = needs_port(ll_valid, ll_rd);

  always_comb begin
    wb_ready = 1'b1;
    ll_ready = 1'b1;
    gnt      = GNT_NONE;
    if (ll_prio) begin
      wb_ready = !ll_live || (wb_rd == '0);
      if (ll_live)      gnt = GNT_LL;
      else if (wb_live) gnt = GNT_WB;
    end else begin
      ll_ready = !wb_live || (ll_rd == '0);
      if (wb_live)      gnt = GNT_WB;
      else if (ll_live) gnt = GNT_LL;
    end
  end

  // Refusal streak of the long-latency source; any acceptance or idle cycle
  // restarts it.
  always_comb begin
    wait_cnt_d = '0;
    if (ll_valid && !ll_ready) begin
      wait_cnt_d = ll_prio ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  // Write port: address and data hold their last granted values when idle.
  always_comb begin
    rfwr_d = 1'b0;
    a3_d   = a3_q;
    wd_d   = wd_q;
    unique case (gnt)
      GNT_WB: begin
        rfwr_d = 1'b1;
        a3_d   = wb_rd;
        wd_d   = wb_data;
      end
      GNT_LL: begin
        rfwr_d = 1'b1;
        a3_d   = ll_rd;
        wd_d   = ll_data;
      end
      default: rfwr_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      rfwr_q     <= 1'b0;
      a3_q       <= '0;
      wd_q       <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rfwr_q     <= rfwr_d;
      a3_q       <= a3_d;
      wd_q       <= wd_d;
    end
  end

  assign RFWr = rfwr_q;
  assign A3   = a3_q;
  assign WD   = wd_q;

  // -------------------------------------------------------------------------
  // Scoreboard: a long-latency result retires its reservation when accepted,
  // including r0 results, which still count against the in-flight limit.
  // -------------------------------------------------------------------------
  rf_scoreboard #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .iss_ll    (iss_ll),
    .ll_ret    (ll_valid && ll_ready),
    .ll_ret_rd (ll_rd),
    .iss_stall (iss_stall),
    .out_cnt   (busy_cnt)
  );

endmodule

// File: tb/tb_rf_wb_sched.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_sched
// Directed scenarios with literal expectations, then randomized traffic.
// A behavioural model (arrays and counters) is compared against the DUT on
// every falling edge; inputs change just after each rising edge.
// ---------------------------------------------------------------------------
module tb_rf_wb_sched;

  localparam int MAX_WAIT = 4;
  localparam int MAX_OUT  = 4;
  localparam int CNT_W    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
  logic        iss_ll = 1'b0;
  logic        iss_stall;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        wb_ready;
  logic        ll_valid = 1'b0;
  logic [4:0]  ll_rd = '0;
  logic [31:0] ll_data = '0;
  logic        ll_ready;
  logic        RFWr;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic [CNT_W-1:0] busy_cnt;

  always #5 clk = ~clk;

  rf_wb_sched #(
    .MAX_WAIT        (MAX_WAIT),
    .MAX_OUTSTANDING (MAX_OUT),
    .CNT_W           (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .iss_ll    (iss_ll),
    .iss_stall (iss_stall),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_ready  (wb_ready),
    .ll_valid  (ll_valid),
    .ll_rd     (ll_rd),
    .ll_data   (ll_data),
    .ll_ready  (ll_ready),
    .RFWr      (RFWr),
    .A3        (A3),
    .WD        (WD),
    .busy_cnt  (busy_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Behavioural model: what the register file port and scoreboard must look
  // like, derived from the arbitration and scoreboard rules.
  // ------------------------------------------------------------------------
  bit          m_busy [32];
  int          m_out;
  int          m_wait;
  bit          m_rfwr;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  bit          m_wb_acc, m_ll_acc;
  int          m_refuse;
  bit          rand_phase = 1'b0;
  logic [4:0]  pend_q [$];

  bit e_prio, e_wb_live, e_ll_live, e_wbr, e_llr, e_stall, e_fire;

  initial forever begin
    @(negedge clk or posedge rst);
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_out    = 0;
      m_wait   = 0;
      m_rfwr   = 1'b0;
      m_a3     = '0;
      m_wd     = '0;
      m_wb_acc = 1'b0;
      m_ll_acc = 1'b0;
      m_refuse = 0;
      pend_q.delete();
    end else begin
      e_prio    = (m_wait >= MAX_WAIT);
      e_wb_live = wb_valid && (wb_rd != 0);
      e_ll_live = ll_valid && (ll_rd != 0);
      e_wbr     = e_prio ? (!e_ll_live || wb_rd == 0) : 1'b1;
      e_llr     = e_prio ? 1'b1 : (!e_wb_live || ll_rd == 0);
      e_stall   = (iss_valid && (m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_rd]))
                  || (iss_ll && m_out == MAX_OUT);

      check("iss_stall", {31'd0, iss_stall}, {31'd0, e_stall});
      check("wb_ready",  {31'd0, wb_ready},  {31'd0, e_wbr});
      check("ll_ready",  {31'd0, ll_ready},  {31'd0, e_llr});
      check("RFWr",      {31'd0, RFWr},      {31'd0, m_rfwr});
      check("A3",        {27'd0, A3},        {27'd0, m_a3});
      check("WD",        WD,                 m_wd);
      check("busy_cnt",  {29'd0, busy_cnt},  32'(m_out));

      // Starvation bound observed directly on the DUT handshake.
      if (ll_valid) begin
        m_refuse = ll_ready ? 0 : m_refuse + 1;
        check("ll_starve", {31'd0, (m_refuse > MAX_WAIT)}, 32'd0);
      end else begin
        m_refuse = 0;
      end

      // State after the coming rising edge.
      if (e_wb_live && e_wbr) begin
        m_rfwr = 1'b1; m_a3 = wb_rd; m_wd = wb_data;
      end else if (e_ll_live && e_llr) begin
        m_rfwr = 1'b1; m_a3 = ll_rd; m_wd = ll_data;
      end else begin
        m_rfwr = 1'b0;
      end
      m_wb_acc = wb_valid && e_wbr;
      m_ll_acc = ll_valid && e_llr;
      m_wait   = (ll_valid && !e_llr) ? ((m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1) : 0;
      e_fire   = iss_valid && !e_stall && iss_ll;
      if (m_ll_acc) m_busy[ll_rd] = 1'b0;
      if (e_fire && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      if (e_fire && !m_ll_acc) m_out++;
      else if (m_ll_acc && !e_fire && m_out > 0) m_out--;
      if (e_fire && rand_phase) pend_q.push_back(iss_rd);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_ll_op(input logic [4:0] rd);
    iss_valid = 1'b1; iss_ll = 1'b1; iss_rd = rd; iss_rs1 = '0; iss_rs2 = '0;
    cyc();
    iss_valid = 1'b0; iss_ll = 1'b0; iss_rd = '0;
  endtask

  int idx;

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    check("rst_RFWr",  {31'd0, RFWr}, 32'd0);
    check("rst_A3",    {27'd0, A3}, 32'd0);
    check("rst_WD",    WD, 32'd0);
    check("rst_cnt",   {29'd0, busy_cnt}, 32'd0);
    check("rst_stall", {31'd0, iss_stall}, 32'd0);

    // ---------------- mid-cycle reset with busy[5] and a grant in flight ----
    iss_valid = 1'b1; iss_ll = 1'b1; iss_rd = 5'd5;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
    cyc();
    iss_ll = 1'b0; iss_rd = '0; iss_rs1 = 5'd5; wb_valid = 1'b0;
    #1;
    check("busy5_stall", {31'd0, iss_stall}, 32'd1);
    check("pre_rst_A3",  {27'd0, A3}, 32'd3);
    rst = 1'b1;
    #1;
    check("mid_rst_RFWr",  {31'd0, RFWr}, 32'd0);
    check("mid_rst_A3",    {27'd0, A3}, 32'd0);
    check("mid_rst_WD",    WD, 32'd0);
    check("mid_rst_stall", {31'd0, iss_stall}, 32'd0);
    rst = 1'b0;
    iss_valid = 1'b0; iss_rs1 = '0;
    cyc();

    // ---------------- single pipeline write ----------------
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234;
    #1 check("wb_only_ready", {31'd0, wb_ready}, 32'd1);
    cyc();
    wb_valid = 1'b0;
    check("wb_RFWr", {31'd0, RFWr}, 32'd1);
    check("wb_A3",   {27'd0, A3}, 32'd3);
    check("wb_WD",   WD, 32'h1234);
    cyc();
    check("wb_RFWr_off", {31'd0, RFWr}, 32'd0);
    check("wb_A3_hold",  {27'd0, A3}, 32'd3);

    // ---------------- LL starvation bound ----------------
    issue_ll_op(5'd7);
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'hAA;
    for (int k = 0; k < MAX_WAIT; k++) begin
      #1;
      check("starve_ll_ready", {31'd0, ll_ready}, 32'd0);
      check("starve_wb_ready", {31'd0, wb_ready}, 32'd1);
      cyc();
    end
    #1;
    check("prio_ll_ready", {31'd0, ll_ready}, 32'd1);
    check("prio_wb_ready", {31'd0, wb_ready}, 32'd0);
    cyc();
    ll_valid = 1'b0;
    check("prio_A3", {27'd0, A3}, 32'd7);
    check("prio_WD", WD, 32'hAA);
    cyc();
    wb_valid = 1'b0;
    check("after_prio_A3", {27'd0, A3}, 32'd4);
    check("after_prio_WD", WD, 32'h44);
    cyc();

    // ---------------- RAW stall until LL return ----------------
    issue_ll_op(5'd9);
    iss_valid = 1'b1; iss_ll = 1'b0; iss_rs1 = 5'd9; iss_rd = 5'd10;
    for (int k = 0; k < 3; k++) begin
      #1 check("raw_stall", {31'd0, iss_stall}, 32'd1);
      cyc();
    end
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h99;
    #1;
    check("raw_ret_ready", {31'd0, ll_ready}, 32'd1);
    check("raw_still_stall", {31'd0, iss_stall}, 32'd1);
    cyc();
    ll_valid = 1'b0;
    check("raw_released", {31'd0, iss_stall}, 32'd0);
    check("raw_A3", {27'd0, A3}, 32'd9);
    iss_valid = 1'b0; iss_rs1 = '0; iss_rd = '0;
    cyc();

    // ---------------- outstanding limit ----------------
    for (int r = 1; r <= 4; r++) begin
      iss_valid = 1'b1; iss_ll = 1'b1; iss_rd = 5'(r); iss_rs1 = '0; iss_rs2 = '0;
      cyc();
    end
    iss_rd = 5'd5;
    #1;
    check("lim_cnt4",  {29'd0, busy_cnt}, 32'd4);
    check("lim_stall", {31'd0, iss_stall}, 32'd1);
    ll_valid = 1'b1; ll_rd = 5'd1; ll_data = 32'h11;
    cyc();
    ll_valid = 1'b0;
    check("lim_cnt3",    {29'd0, busy_cnt}, 32'd3);
    check("lim_proceed", {31'd0, iss_stall}, 32'd0);
    cyc();
    iss_valid = 1'b0; iss_ll = 1'b0; iss_rd = '0;
    check("lim_cnt4b", {29'd0, busy_cnt}, 32'd4);
    for (int r = 2; r <= 5; r++) begin
      ll_valid = 1'b1; ll_rd = 5'(r); ll_data = 32'(r);
      cyc();
    end
    ll_valid = 1'b0;
    check("lim_drained", {29'd0, busy_cnt}, 32'd0);

    // ---------------- r0 write-back alongside LL ----------------
    issue_ll_op(5'd7);
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h77;
    #1;
    check("r0_wb_ready", {31'd0, wb_ready}, 32'd1);
    check("r0_ll_ready", {31'd0, ll_ready}, 32'd1);
    cyc();
    wb_valid = 1'b0; ll_valid = 1'b0;
    check("r0_RFWr", {31'd0, RFWr}, 32'd1);
    check("r0_A3",   {27'd0, A3}, 32'd7);
    check("r0_WD",   WD, 32'h77);
    cyc();
    check("r0_RFWr_off", {31'd0, RFWr}, 32'd0);

    // ---------------- randomized traffic ----------------
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rand_phase = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (!(wb_valid && !m_wb_acc)) begin
        wb_valid = 1'($urandom_range(0, 1));
        wb_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        wb_data  = $urandom;
      end
      if (!(ll_valid && !m_ll_acc)) begin
        ll_valid = 1'b0;
        if (pend_q.size() > 0 && $urandom_range(0, 2) == 0) begin
          idx = int'($urandom_range(0, pend_q.size() - 1));
          ll_rd = pend_q[idx];
          pend_q.delete(idx);
          ll_valid = 1'b1;
          ll_data  = $urandom;
        end
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_ll    = 1'($urandom_range(0, 1));
      iss_rs1   = 5'($urandom_range(0, 7));
      iss_rs2   = 5'($urandom_range(0, 7));
      iss_rd    = 5'($urandom_range(0, 7));
    end
    iss_valid = 1'b0; wb_valid = 1'b0; ll_valid = 1'b0;
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
